frame_wr_ctrl: RTL

Upstream write controller for the matrix-transpose frame buffer. It accepts a row-major pixel stream over a valid/ready handshake, writes one frame of ROW×CLO words into the single-port-write RAM at sequential addresses, then pulses `rd_command` so the column-order reader drains the frame. It holds off the stream with `s_ready` until the reader reports `rd_finish`, so a frame is never overwritten while it is being read.

---
 rtl/frame_wr_ctrl_pkg.sv | 16 +
 rtl/frame_wr_ctrl_if.sv | 15 +
 rtl/frame_wr_ctrl.sv | 138 +++++++++++++
 3 files changed

// File: rtl/frame_wr_ctrl_pkg.sv
// Shared definitions for the matrix-transpose frame buffer controllers.
// Holds the default frame geometry and the write-controller state type.
package matrix_pkg;

    localparam int DEF_ROW     = 64;
    localparam int DEF_CLO     = 2400;
    localparam int FRAME_WORDS = DEF_ROW * DEF_CLO;

    typedef enum logic [1:0] {
        IDLE,
        WRITE,
        KICK,
        WAIT_RD
    } wr_state_e;

endpackage

// File: rtl/frame_wr_ctrl_if.sv
// Row-major pixel stream into the frame write controller (valid/ready
// handshake with a start-of-frame marker).
interface frame_wr_ctrl_if #(
    parameter int DATA_WIDTH = 32
) ();

    logic                  s_valid;
    logic                  s_ready;
    logic [DATA_WIDTH-1:0] s_data;
    logic                  s_sof;

    modport master (output s_valid, output s_data, output s_sof, input s_ready);
    modport slave  (input s_valid, input s_data, input s_sof, output s_ready);

endinterface

// File: rtl/frame_wr_ctrl.sv
// Frame write controller: writes one ROW*CLO frame into the transpose RAM at
// sequential addresses, kicks the column reader, then holds off the stream
// until the reader reports it has drained the frame.
// Optional feature macro: FRAME_WR_CTRL_ERR_CNT_EN adds a saturating
// 16-bit framing-error counter on port err_cnt.
module frame_wr_ctrl
    import matrix_pkg::*;
#(
    parameter int ADDR_WIDTH = 18,
    parameter int DATA_WIDTH = 32,
    parameter int ROW        = DEF_ROW,
    parameter int CLO        = DEF_CLO
) (
    input  logic                  clk,
    input  logic                  rst_n,
    frame_wr_ctrl_if.slave        s,
    output logic                  wr_en,
    output logic [ADDR_WIDTH-1:0] wr_addr,
    output logic [DATA_WIDTH-1:0] wr_data,
    output logic                  rd_command,
    input  logic                  rd_finish,
    output logic                  frame_err,
    output logic                  busy
`ifdef FRAME_WR_CTRL_ERR_CNT_EN
    ,
    output logic [15:0]           err_cnt
`endif
);

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(ROW * CLO - 1);

    wr_state_e             state, state_d;
    logic [ADDR_WIDTH-1:0] cnt, cnt_d;
    logic [ADDR_WIDTH-1:0] addr_d;
    logic                  ready_q;
    logic                  accept;
    logic                  wr_en_d;
    logic                  err_d;

    assign accept    = s.s_valid && ready_q;
    assign s.s_ready = ready_q;
    assign busy      = (state != IDLE);

    // Next state, next write address counter and next registered outputs.
    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        addr_d  = '0;
        wr_en_d = 1'b0;
        err_d   = 1'b0;
        case (state)
            IDLE, WRITE: begin
                if (accept) begin
                    if (s.s_sof) begin
                        // SOF always restarts at address 0; in WRITE it is a resync.
                        wr_en_d = 1'b1;
                        addr_d  = '0;
                        err_d   = (state == WRITE);
                        if (LAST_ADDR == '0) begin
                            state_d = KICK;
                        end else begin
                            state_d = WRITE;
                            cnt_d   = ADDR_WIDTH'(1);
                        end
                    end else if (state == IDLE) begin
                        err_d = 1'b1;
                    end else begin
                        wr_en_d = 1'b1;
                        addr_d  = cnt;
                        if (cnt == LAST_ADDR) begin
                            state_d = KICK;
                        end else begin
                            cnt_d = cnt + 1'b1;
                        end
                    end
                end
            end
            KICK: begin
                state_d = WAIT_RD;
            end
            WAIT_RD: begin
                if (rd_finish) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        if (state_d == IDLE) begin
            cnt_d = '0;
        end
    end

    // State and address counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_d;
            cnt   <= cnt_d;
        end
    end

    // Registered handshake, RAM write port and event pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ready_q    <= 1'b0;
            wr_en      <= 1'b0;
            wr_addr    <= '0;
            wr_data    <= '0;
            frame_err  <= 1'b0;
            rd_command <= 1'b0;
        end else begin
            ready_q    <= (state_d == IDLE) || (state_d == WRITE);
            wr_en      <= wr_en_d;
            frame_err  <= err_d;
            rd_command <= (state == KICK);
            if (wr_en_d) begin
                wr_addr <= addr_d;
                wr_data <= s.s_data;
            end
        end
    end

`ifdef FRAME_WR_CTRL_ERR_CNT_EN
    // Saturating count of framing-error pulses, cleared only by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_cnt <= '0;
        end else if (frame_err && (err_cnt != '1)) begin
            err_cnt <= err_cnt + 16'd1;
        end
    end
`endif

endmodule
